// File: rtl/ioctl_load_router.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_load_router
//  Description : Routes the hps_io ioctl download stream into NREG contiguous
//                ROM regions with rebased addresses and per-region strobes,
//                captures DIP switch bytes, and sequences the core reset
//                around ROM loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module ioctl_load_router #(
    parameter int                     ADDR_W      = 25,
    parameter int                     DATA_W      = 8,
    parameter int                     NREG        = 4,
    parameter int                     REG_AW      = 17,
    parameter logic [NREG*32-1:0]     BOUNDS      = {32'd65536, 32'd32768, 32'd16384, 32'd8192},
    parameter logic [7:0]             ROM_INDEX   = 8'd0,
    parameter logic [7:0]             DIP_INDEX   = 8'd254,
    parameter int                     DIP_BYTES   = 8,
    parameter logic [DIP_BYTES*8-1:0] DIP_DEFAULT = '0,
    parameter int                     HOLD_CYCLES = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [DATA_W-1:0]      ioctl_dout,
    output logic [NREG-1:0]        dl_wr,
    output logic [REG_AW-1:0]      dl_addr,
    output logic [DATA_W-1:0]      dl_data,
    output logic [NREG-1:0]        region_done,
    output logic [DIP_BYTES*8-1:0] dip_out,
    output logic                   dip_valid,
    output logic                   core_reset,
    output logic                   rom_loading,
    output logic                   overflow
);

    // Comparison width wide enough for both the ioctl address and 32-bit bounds
    localparam int CMP_W  = (ADDR_W > 32) ? ADDR_W : 32;
    localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DIP_AW = (DIP_BYTES > 1) ? $clog2(DIP_BYTES) : 1;
    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     dl_prev_q;
    logic                     core_reset_q;

    logic [NREG-1:0]          dl_wr_q, dl_wr_d;
    logic [REG_AW-1:0]        dl_addr_q, dl_addr_d;
    logic [DATA_W-1:0]        dl_data_q, dl_data_d;
    logic [NREG-1:0]          region_done_q, region_done_d;
    logic                     overflow_q, overflow_d;
    logic [DIP_BYTES*8-1:0]   dip_q, dip_d;
    logic                     dip_valid_q, dip_valid_d;

    logic                     w_rom_idx;
    logic                     w_rom_rise;
    logic                     w_rom_wr;
    logic                     w_enter_load;
    logic                     w_dip_we;
    logic [CMP_W-1:0]         w_addr_ext;
    logic [CMP_W-1:0]         w_lo;
    logic [CMP_W-1:0]         w_hi;
    logic [CMP_W-1:0]         w_base;
    logic [NREG-1:0]          w_hit;
    logic [NREG-1:0]          w_last;
    logic                     w_ovf;

    // A download start is only a new load when the ROM index is present at the rise.
    // Bytes are accepted only inside a load (or in its rise cycle), so a stream that
    // was already running across a reset stays ignored until the next clean rise.
    assign w_rom_idx    = (ioctl_index == ROM_INDEX);
    assign w_rom_rise   = ioctl_download & ~dl_prev_q & w_rom_idx;
    assign w_rom_wr     = ioctl_wr & ioctl_download & w_rom_idx &
                          ((state_q == ST_LOAD) | w_rom_rise);
    assign w_enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign w_dip_we     = ioctl_wr & (ioctl_index == DIP_INDEX) &
                          (ioctl_addr < ADDR_W'(DIP_BYTES));
    assign w_addr_ext   = CMP_W'(ioctl_addr);

    // Region decode: walk the ascending bounds, each region starting at the previous bound
    always_comb begin
        w_hit  = '0;
        w_last = '0;
        w_base = '0;
        w_lo   = '0;
        w_hi   = '0;
        for (int i = 0; i < NREG; i++) begin
            w_hi = CMP_W'(BOUNDS[32*i +: 32]);
            if ((w_addr_ext >= w_lo) && (w_addr_ext < w_hi)) begin
                w_hit[i]  = 1'b1;
                w_last[i] = (w_addr_ext == (w_hi - 1'b1));
                w_base    = w_lo;
            end
            w_lo = w_hi;
        end
        // After the walk w_lo holds the top bound of the last region
        w_ovf = (w_addr_ext >= w_lo);
    end

    // Next-state for the routed write port, completion flags and DIP bank
    always_comb begin
        dl_wr_d       = w_rom_wr ? w_hit : '0;
        dl_addr_d     = dl_addr_q;
        dl_data_d     = dl_data_q;
        region_done_d = w_enter_load ? '0 : region_done_q;
        overflow_d    = w_enter_load ? 1'b0 : overflow_q;
        dip_d         = dip_q;
        dip_valid_d   = dip_valid_q;
        if (w_rom_wr && (w_hit != '0)) begin
            // Offset is formed at ioctl width then truncated; oversized regions alias
            dl_addr_d = REG_AW'(ioctl_addr - ADDR_W'(w_base));
            dl_data_d = ioctl_dout;
        end
        // Set of the byte's own region wins over the load-entry clear
        if (w_rom_wr) begin
            region_done_d = region_done_d | w_last;
            overflow_d    = overflow_d | w_ovf;
        end
        if (w_dip_we) begin
            for (int k = 0; k < DIP_BYTES; k++) begin
                if (ioctl_addr[DIP_AW-1:0] == DIP_AW'(k)) begin
                    dip_d[8*k +: 8] = ioctl_dout[7:0];
                end
            end
            dip_valid_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_wr_q       <= '0;
            dl_addr_q     <= '0;
            dl_data_q     <= '0;
            region_done_q <= '0;
            overflow_q    <= 1'b0;
            dip_q         <= DIP_DEFAULT;
            dip_valid_q   <= 1'b0;
        end else begin
            dl_wr_q       <= dl_wr_d;
            dl_addr_q     <= dl_addr_d;
            dl_data_q     <= dl_data_d;
            region_done_q <= region_done_d;
            overflow_q    <= overflow_d;
            dip_q         <= dip_d;
            dip_valid_q   <= dip_valid_d;
        end
    end

    // Load sequencer next-state: BOOT/RUN wait for a ROM load, HOLD stretches reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT, ST_RUN: begin
                if (w_rom_rise) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    state_d = ST_HOLD;
                    cnt_d   = C_HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (w_rom_rise) begin
                    state_d = ST_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Sequencer registers; core_reset rises with entry into LOAD and falls one clock
    // after the sequencer settles in RUN, so the release lands HOLD_CYCLES+1 after
    // the download is seen low. The download register powers up high so a stream
    // still running out of reset is not mistaken for a fresh start.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            cnt_q        <= '0;
            dl_prev_q    <= 1'b1;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dl_prev_q    <= ioctl_download;
            core_reset_q <= (state_d != ST_RUN) || (state_q != ST_RUN);
        end
    end

    assign dl_wr       = dl_wr_q;
    assign dl_addr     = dl_addr_q;
    assign dl_data     = dl_data_q;
    assign region_done = region_done_q;
    assign overflow    = overflow_q;
    assign dip_out     = dip_q;
    assign dip_valid   = dip_valid_q;
    assign core_reset  = core_reset_q;
    assign rom_loading = (state_q == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_ioctl_load_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_load_router
//  Description : Self-checking bench for ioctl_load_router (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_load_router;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [3:0]  dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic [3:0]  region_done;
    logic [63:0] dip_out;
    logic        dip_valid;
    logic        core_reset;
    logic        rom_loading;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Region upper bounds, ascending (region i = [bound[i-1], bound[i]))
    int c_bounds[4] = '{8192, 16384, 32768, 65536};

    typedef struct {
        logic [3:0]  wr;
        logic [16:0] addr;
        logic [7:0]  data;
    } sb_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  exp_wr;
        logic [16:0] exp_addr;
        logic [3:0]  exp_done;
        logic        exp_ovf;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[11];

    ioctl_load_router dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .region_done    (region_done),
        .dip_out        (dip_out),
        .dip_valid      (dip_valid),
        .core_reset     (core_reset),
        .rom_loading    (rom_loading),
        .overflow       (overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference region decode from the bench's own bound table
    function automatic sb_t model(input logic [24:0] a, input logic [7:0] d);
        sb_t r;
        int  lo;
        r.wr   = '0;
        r.addr = '0;
        r.data = d;
        lo     = 0;
        for (int i = 0; i < 4; i++) begin
            if ((int'(a) >= lo) && (int'(a) < c_bounds[i])) begin
                r.wr[i] = 1'b1;
                r.addr  = 17'(int'(a) - lo);
            end
            lo = c_bounds[i];
        end
        return r;
    endfunction

    task automatic push_wr(input logic [24:0] a, input logic [7:0] d);
        sb_t e;
        e = model(a, d);
        if (e.wr != 4'b0) sb_q.push_back(e);
    endtask

    // Call right after driving ioctl_download low at a negedge
    task automatic measure_release(input string name);
        int n;
        n = 0;
        @(posedge clk_sys);
        #1;
        chk({name, "_held"}, core_reset, 1'b1);
        while (core_reset && (n < 40)) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        chk(name, n, 17);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation
    always @(negedge clk_sys) begin
        if (reset_n && (dl_wr != 4'b0)) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got dl_wr=%b addr=%0h required no strobe", dl_wr, dl_addr);
            end else begin
                mon_e = sb_q.pop_front();
                n_tests++;
                if ((dl_wr !== mon_e.wr) || (dl_addr !== mon_e.addr) || (dl_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL sb_write: got wr=%b addr=%0h data=%0h required wr=%b addr=%0h data=%0h",
                             dl_wr, dl_addr, dl_data, mon_e.wr, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        logic [7:0] last_d;

        vecs[0]  = '{25'h0000000, 8'h11, 4'b0001, 17'h00000, 4'b0000, 1'b0};
        vecs[1]  = '{25'h0001FFF, 8'h22, 4'b0001, 17'h01FFF, 4'b0001, 1'b0};
        vecs[2]  = '{25'h0002000, 8'h33, 4'b0010, 17'h00000, 4'b0001, 1'b0};
        vecs[3]  = '{25'h0003FFF, 8'h44, 4'b0010, 17'h01FFF, 4'b0011, 1'b0};
        vecs[4]  = '{25'h0004000, 8'h55, 4'b0100, 17'h00000, 4'b0011, 1'b0};
        vecs[5]  = '{25'h0005A5A, 8'h66, 4'b0100, 17'h01A5A, 4'b0011, 1'b0};
        vecs[6]  = '{25'h0007FFF, 8'h77, 4'b0100, 17'h03FFF, 4'b0111, 1'b0};
        vecs[7]  = '{25'h0008000, 8'h88, 4'b1000, 17'h00000, 4'b0111, 1'b0};
        vecs[8]  = '{25'h000FFFF, 8'h99, 4'b1000, 17'h07FFF, 4'b1111, 1'b0};
        vecs[9]  = '{25'h0010000, 8'hAA, 4'b0000, 17'h07FFF, 4'b1111, 1'b1};
        vecs[10] = '{25'h1FFFFFF, 8'hBB, 4'b0000, 17'h07FFF, 4'b1111, 1'b1};

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;

        // ---- reset values ----
        repeat (3) @(negedge clk_sys);
        chk("rst_core_reset", core_reset, 1'b1);
        chk("rst_dl_wr", dl_wr, 4'b0);
        chk("rst_dl_addr", dl_addr, 17'h0);
        chk("rst_dip_out", dip_out, 64'h0);
        chk("rst_dip_valid", dip_valid, 1'b0);
        chk("rst_region_done", region_done, 4'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_rom_loading", rom_loading, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("boot_core_reset", core_reset, 1'b1);

        // ---- full ROM load, first byte in the rise cycle ----
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        for (int a = 0; a < 65536; a++) begin
            if (a == 2) begin
                chk("load_rom_loading", rom_loading, 1'b1);
                chk("load_core_reset", core_reset, 1'b1);
            end
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(a);
            ioctl_dout = 8'(a ^ (a >> 8));
            push_wr(ioctl_addr, ioctl_dout);
            @(negedge clk_sys);
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        chk("full_region_done", region_done, 4'b1111);
        chk("full_overflow", overflow, 1'b0);
        measure_release("full_release");
        @(negedge clk_sys);
        chk("full_sb_drained", sb_q.size(), 0);
        chk("run_core_reset", core_reset, 1'b0);
        chk("run_rom_loading", rom_loading, 1'b0);

        // ---- second load: table of boundary addresses ----
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("reload_done_clear", region_done, 4'b0);
        chk("reload_rom_loading", rom_loading, 1'b1);
        chk("reload_core_reset", core_reset, 1'b1);
        last_d = dl_data;
        for (int v = 0; v < 11; v++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = vecs[v].addr;
            ioctl_dout = vecs[v].data;
            if (vecs[v].exp_wr != 4'b0) begin
                sb_q.push_back('{vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].data});
                last_d = vecs[v].data;
            end
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            chk($sformatf("vec%0d_wr", v), dl_wr, vecs[v].exp_wr);
            chk($sformatf("vec%0d_addr", v), dl_addr, vecs[v].exp_addr);
            chk($sformatf("vec%0d_data", v), dl_data, last_d);
            chk($sformatf("vec%0d_done", v), region_done, vecs[v].exp_done);
            chk($sformatf("vec%0d_ovf", v), overflow, vecs[v].exp_ovf);
            @(negedge clk_sys);
            chk($sformatf("vec%0d_pulse_end", v), dl_wr, 4'b0);
        end

        // ---- reload 5 clocks into the hold stretch ----
        ioctl_download = 1'b0;
        @(posedge clk_sys);
        repeat (5) @(posedge clk_sys);
        #1;
        chk("hold_core_reset", core_reset, 1'b1);
        chk("hold_rom_loading", rom_loading, 1'b0);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h0001FFF;
        ioctl_dout     = 8'hEE;
        push_wr(ioctl_addr, ioctl_dout);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("hold_reload_loading", rom_loading, 1'b1);
        chk("hold_reload_core_reset", core_reset, 1'b1);
        chk("hold_reload_done_setwins", region_done, 4'b0001);
        chk("hold_reload_ovf_clear", overflow, 1'b0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        measure_release("reload_release");

        // ---- DIP capture while running ----
        @(negedge clk_sys);
        chk("dip_valid_before", dip_valid, 1'b0);
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'h5A;
        @(negedge clk_sys);
        chk("dip_byte0", dip_out, 64'h5A);
        chk("dip_valid_first", dip_valid, 1'b1);
        ioctl_addr = 25'd1;  ioctl_dout = 8'hC2;
        @(negedge clk_sys);
        ioctl_addr = 25'd9;  ioctl_dout = 8'hFF;
        @(negedge clk_sys);
        ioctl_addr = 25'd7;  ioctl_dout = 8'h33;
        @(negedge clk_sys);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("dip_bank", dip_out, 64'h3300_0000_0000_C25A);
        chk("dip_core_reset", core_reset, 1'b0);
        chk("dip_rom_loading", rom_loading, 1'b0);

        // ---- asynchronous reset in the middle of a ROM stream ----
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h100;
        ioctl_dout     = 8'h42;
        push_wr(ioctl_addr, ioctl_dout);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_core_reset", core_reset, 1'b1);
        chk("arst_dl_wr", dl_wr, 4'b0);
        chk("arst_dl_data", dl_data, 8'h0);
        chk("arst_dip_out", dip_out, 64'h0);
        chk("arst_dip_valid", dip_valid, 1'b0);
        chk("arst_rom_loading", rom_loading, 1'b0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h200;
        ioctl_dout = 8'h24;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("arst_stream_ignored", dl_wr, 4'b0);
        chk("arst_no_load", rom_loading, 1'b0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h0001FFF;
        ioctl_dout     = 8'h5C;
        push_wr(ioctl_addr, ioctl_dout);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("arst_new_load", rom_loading, 1'b1);
        chk("arst_new_done", region_done, 4'b0001);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("final_sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
